pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Stall/flush controller for the five-stage RV32I pipeline. It drives the enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory accesses through a ready handshake. A timeout counter bounds memory waits and squashes the timed-out access's register write. A saturating performance counter records memory-wait cycles.

## Interface
- `TIMEOUT`, default 16: maximum wait cycles per access, legal range 2..255.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `Rs1D`, `Rs2D` in 5: source registers of the instruction in Decode.
- `RdE` in 5: destination register of the instruction in Execute.
- `ResultSrcE` in 3: result select of the instruction in Execute. A load is `RES_LOAD` = 3'b001.
- `PCSrcE` in 1: taken branch or jump resolved in Execute.
- `MemReqM` in 1: the instruction in Memory performs a load or store.
- `MemReadyM` in 1: data memory completes the access this cycle.
- `StallF` out 1: hold the PC.
- `StallD` out 1: hold IF/ID.
- `FlushD` out 1: bubble into IF/ID.
- `FlushE` out 1: bubble into ID/EX.
- `EN_EM` out 1: EX/MEM enable.
- `EN_MW` out 1: MEM/WB `EN`.
- `KillM` out 1: forces `RegWriteM` to 0 at the MEM/WB input.
- `BusErr` out 1: one-cycle timeout pulse to trap logic.
- `WaitCnt` out 32: saturating count of memory-wait cycles.

## Operation
- The FSM has two states, `RUN` and `MEM_WAIT`. The state is registered. All control outputs are combinational from the state and the current inputs.
- **`RUN`, entering a wait:** if `MemReqM=1` and `MemReadyM=0`, go to `MEM_WAIT`. This cycle is already a wait cycle (see global hold).
- **`RUN`, zero-wait access:** if `MemReqM=1` and `MemReadyM=1`, there is no stall and the state stays `RUN`.
- **`MEM_WAIT`, ready:** on `MemReadyM=1`, release all enables in that same cycle so MEM/WB captures `ReadDataM`, then go to `RUN`.
- **`MEM_WAIT`, timeout:** timeout fires when `cnt == TIMEOUT-1` with no ready. In that cycle:
  - enables are released;
  - `KillM=1`;
  - `BusErr=1`;
  - the next state is `RUN`.
- **Global hold (wait cycle):** every `RUN` or `MEM_WAIT` cycle that has a pending access, no ready and no timeout. During a hold:
  - `StallF`, `StallD` = 1;
  - `EN_EM`, `EN_MW` = 0;
  - `FlushD`, `FlushE` = 0.
  
  Branch and load-use actions are deferred because the Execute contents are frozen and re-evaluated after release.
- **Wait counter `cnt` (8-bit):**
  - loaded with 1 on entering `MEM_WAIT`;
  - incremented each cycle in `MEM_WAIT`;
  - cleared on exit.
- **Branch** (no hold, `PCSrcE=1`): `FlushD`, `FlushE` = 1, with no stall. This overrides load-use, because the Decode instruction is wrong-path.
- **Load-use** (no hold, no branch): the condition is `ResultSrcE==RES_LOAD`, `RdE!=0`, and (`RdE==Rs1D` or `RdE==Rs2D`). Response: `StallF`, `StallD`, `FlushE` = 1. `EN_EM` and `EN_MW` stay 1.
- **Default:** all stalls and flushes are 0, `EN_EM`, `EN_MW` = 1, and `KillM`, `BusErr` = 0.
- **`WaitCnt`:** +1 on every hold cycle, saturating at 32'hFFFF_FFFF.

## Timing
- Hazard, branch and zero-wait responses have zero latency: they are combinational in the same cycle.
- A wait of N cycles (ready in the (N+1)-th cycle of the access) stalls the pipeline for exactly N cycles.
- Timeout: for an access with no ready, `BusErr` pulses in the TIMEOUT-th cycle of the access. That is the cycle after TIMEOUT-1 hold cycles.
- If `MemReadyM` and the timeout coincide, ready wins: `KillM=0`, `BusErr=0`.
- A new access immediately after release starts a fresh wait, and `cnt` reloads to 1.
- While `rst=1`, outputs take the default values and `BusErr=0`.
- At the reset edge:
  - the state becomes `RUN`;
  - `cnt` becomes 0;
  - `WaitCnt` becomes 0.
- Reset mid-wait abandons the access with no `BusErr` pulse.

## Structure
- Package `rv_pipe_pkg` holds:
  - the `RES_LOAD` and other `ResultSrc` encodings;
  - the FSM state enum (`RUN`, `MEM_WAIT`);
  - the `TIMEOUT` default.
- One sub-module, `sat_counter`, holds the 32-bit saturating `WaitCnt` with inc and sync clear. The FSM, `cnt` and hazard logic stay in the top module.

## Test plan
- **Load-use:** `ResultSrcE=3'b001`, `RdE=5`, `Rs1D=5`, `PCSrcE=0`, `MemReqM=0` -> `StallF`, `StallD`, `FlushE` = 1, `EN_MW=1`. Repeat with `RdE=0` -> no stall.
- **Branch over load-use:** the same hazard plus `PCSrcE=1` -> `FlushD`, `FlushE` = 1, `StallF`, `StallD` = 0.
- **Wait of 3:** `MemReqM=1`, `MemReadyM` low for 3 cycles then high -> `EN_MW=0` for 3 cycles, 1 on the ready cycle. `WaitCnt`=3, state back in `RUN`.
- **Timeout:** `TIMEOUT=4`, `MemReqM=1`, ready never asserted -> hold for 3 cycles. In the 4th cycle, `BusErr=1`, `KillM=1` and enables are released. `WaitCnt`=3.
- **Deferred branch:** `PCSrcE=1` during a 2-cycle wait -> no flush while held, then `FlushD`, `FlushE` = 1 on the release cycle.
- **Reset mid-wait:** `rst=1` in cycle 2 of a wait -> next cycle state `RUN`, `WaitCnt`=0, no `BusErr` pulse.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the RV32I pipeline control.
// Result-select codes, hazard FSM states and wait defaults.
package rv_pipe_pkg;

  localparam logic [2:0] RES_ALU  = 3'b000;
  localparam logic [2:0] RES_LOAD = 3'b001;
  localparam logic [2:0] RES_PC4  = 3'b010;
  localparam logic [2:0] RES_IMM  = 3'b011;

  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle between pipeline datapath and controller.
// master: datapath side, slave: controller side.
interface pipe_hazard_ctrl_if;

  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdE;
  logic [2:0]  ResultSrcE;
  logic        PCSrcE;
  logic        MemReqM;
  logic        MemReadyM;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        FlushE;
  logic        EN_EM;
  logic        EN_MW;
  logic        KillM;
  logic        BusErr;
  logic [31:0] WaitCnt;

  modport master (
    output Rs1D, Rs2D, RdE, ResultSrcE,
    output PCSrcE, MemReqM, MemReadyM,
    input  StallF, StallD, FlushD, FlushE,
    input  EN_EM, EN_MW, KillM, BusErr,
    input  WaitCnt
  );

  modport slave (
    input  Rs1D, Rs2D, RdE, ResultSrcE,
    input  PCSrcE, MemReqM, MemReadyM,
    output StallF, StallD, FlushD, FlushE,
    output EN_EM, EN_MW, KillM, BusErr,
    output WaitCnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: load-use, branch flush, memory waits.
// Memory waits freeze the whole pipe and are bounded by TIMEOUT.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  hz_state_e  state_q;
  hz_state_e  state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  logic pending;
  logic tmo;
  logic hold;
  logic branch;
  logic load_use;

  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;
  logic en_em;
  logic en_mw;
  logic kill_m;
  logic bus_err;

  // A held access stays pending in MEM_WAIT even if MemReqM drops.
  assign pending = (state_q == MEM_WAIT) || hz.MemReqM;
  assign tmo     = (state_q == MEM_WAIT) && !hz.MemReadyM
                && (cnt_q == TO_LAST);
  assign hold    = !rst && pending && !hz.MemReadyM && !tmo;

  assign branch   = !rst && !hold && hz.PCSrcE;
  assign load_use = !rst && !hold && !hz.PCSrcE
                 && (hz.ResultSrcE == RES_LOAD)
                 && (hz.RdE != 5'd0)
                 && ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      RUN: begin
        if (hz.MemReqM && !hz.MemReadyM) begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (hz.MemReadyM || tmo)
          state_d = RUN;
        else
          cnt_d = cnt_q + 8'd1;
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    en_em   = 1'b1;
    en_mw   = 1'b1;
    kill_m  = !rst && tmo;
    bus_err = !rst && tmo;
    unique case (1'b1)
      hold: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        en_em   = 1'b0;
        en_mw   = 1'b0;
      end
      branch: begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end
      load_use: begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.StallF = stall_f;
  assign hz.StallD = stall_d;
  assign hz.FlushD = flush_d;
  assign hz.FlushE = flush_e;
  assign hz.EN_EM  = en_em;
  assign hz.EN_MW  = en_mw;
  assign hz.KillM  = kill_m;
  assign hz.BusErr = bus_err;

  sat_counter #(
    .W (32)
  ) u_wait_cnt (
    .clk (clk),
    .clr (rst),
    .inc (hold),
    .cnt (hz.WaitCnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4.
// Control vector order: StallF StallD FlushD FlushE EN_EM EN_MW KillM BusErr.
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] V_DEF  = 8'b0000_1100;
  localparam logic [7:0] V_HOLD = 8'b1100_0000;
  localparam logic [7:0] V_BR   = 8'b0011_1100;
  localparam logic [7:0] V_LU   = 8'b1101_1100;
  localparam logic [7:0] V_TMO  = 8'b0000_1111;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz.slave)
  );

  logic [7:0] ctl;
  assign ctl = {hz.StallF, hz.StallD, hz.FlushD, hz.FlushE,
                hz.EN_EM, hz.EN_MW, hz.KillM, hz.BusErr};

  task automatic idle();
    hz.Rs1D       = 5'd0;
    hz.Rs2D       = 5'd0;
    hz.RdE        = 5'd0;
    hz.ResultSrcE = 3'b000;
    hz.PCSrcE     = 1'b0;
    hz.MemReqM    = 1'b0;
    hz.MemReadyM  = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    hz.MemReqM    = 1'b1;
    hz.PCSrcE     = 1'b1;
    hz.ResultSrcE = 3'b001;
    hz.RdE        = 5'd7;
    hz.Rs1D       = 5'd7;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL reset_ctl got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    tick();
    checks++;
    if (hz.WaitCnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_waitcnt got=%0d exp=0", hz.WaitCnt);
    end
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=%b", ctl, V_DEF);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hz.ResultSrcE = 3'b001;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    hz.Rs2D       = 5'd9;
    #1;
    checks++;
    if (ctl !== V_LU) begin
      errors++;
      $display("FAIL lu_rs1 got=%b exp=%b", ctl, V_LU);
    end
    hz.Rs1D = 5'd3;
    hz.Rs2D = 5'd5;
    #1;
    checks++;
    if (ctl !== V_LU) begin
      errors++;
      $display("FAIL lu_rs2 got=%b exp=%b", ctl, V_LU);
    end
    hz.RdE  = 5'd0;
    hz.Rs1D = 5'd0;
    hz.Rs2D = 5'd0;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL lu_rd0 got=%b exp=%b", ctl, V_DEF);
    end
    hz.ResultSrcE = 3'b000;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL lu_not_load got=%b exp=%b", ctl, V_DEF);
    end
    hz.ResultSrcE = 3'b001;
    hz.Rs1D       = 5'd6;
    hz.Rs2D       = 5'd4;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL lu_no_match got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    hz.ResultSrcE = 3'b001;
    hz.RdE        = 5'd5;
    hz.Rs1D       = 5'd5;
    hz.PCSrcE     = 1'b1;
    #1;
    checks++;
    if (ctl !== V_BR) begin
      errors++;
      $display("FAIL branch_over_lu got=%b exp=%b", ctl, V_BR);
    end
    hz.MemReqM   = 1'b1;
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== V_BR) begin
      errors++;
      $display("FAIL branch_zero_wait got=%b exp=%b", ctl, V_BR);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL branch_after got=%b exp=%b", ctl, V_DEF);
    end
  endtask

  task automatic test_wait3();
    do_reset();
    hz.MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== V_HOLD) begin
        errors++;
        $display("FAIL wait3_hold%0d got=%b exp=%b", i, ctl, V_HOLD);
      end
      tick();
    end
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL wait3_release got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL wait3_run got=%b exp=%b", ctl, V_DEF);
    end
    checks++;
    if (hz.WaitCnt !== 32'd3) begin
      errors++;
      $display("FAIL wait3_waitcnt got=%0d exp=3", hz.WaitCnt);
    end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    hz.MemReqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== V_HOLD) begin
        errors++;
        $display("FAIL tmo_hold%0d got=%b exp=%b", i, ctl, V_HOLD);
      end
      tick();
    end
    #1;
    checks++;
    if (ctl !== V_TMO) begin
      errors++;
      $display("FAIL tmo_fire got=%b exp=%b", ctl, V_TMO);
    end
    tick();
    idle();
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL tmo_after got=%b exp=%b", ctl, V_DEF);
    end
    checks++;
    if (hz.WaitCnt !== 32'd3) begin
      errors++;
      $display("FAIL tmo_waitcnt got=%0d exp=3", hz.WaitCnt);
    end
    tick();
  endtask

  task automatic test_ready_wins();
    do_reset();
    hz.MemReqM = 1'b1;
    tick();
    tick();
    tick();
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL ready_wins got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    idle();
  endtask

  task automatic test_deferred_branch();
    do_reset();
    hz.MemReqM = 1'b1;
    hz.PCSrcE  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== V_HOLD) begin
        errors++;
        $display("FAIL defbr_hold%0d got=%b exp=%b", i, ctl, V_HOLD);
      end
      tick();
    end
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== V_BR) begin
      errors++;
      $display("FAIL defbr_release got=%b exp=%b", ctl, V_BR);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hz.WaitCnt !== 32'd2) begin
      errors++;
      $display("FAIL defbr_waitcnt got=%0d exp=2", hz.WaitCnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hz.MemReqM = 1'b1;
    tick();
    hz.MemReadyM = 1'b1;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL b2b_release got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    hz.MemReadyM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== V_HOLD) begin
        errors++;
        $display("FAIL b2b_hold%0d got=%b exp=%b", i, ctl, V_HOLD);
      end
      tick();
    end
    #1;
    checks++;
    if (ctl !== V_TMO) begin
      errors++;
      $display("FAIL b2b_tmo got=%b exp=%b", ctl, V_TMO);
    end
    tick();
    idle();
    #1;
    checks++;
    if (hz.WaitCnt !== 32'd4) begin
      errors++;
      $display("FAIL b2b_waitcnt got=%0d exp=4", hz.WaitCnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    hz.MemReqM = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL rmw_in_reset got=%b exp=%b", ctl, V_DEF);
    end
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (ctl !== V_DEF) begin
      errors++;
      $display("FAIL rmw_run got=%b exp=%b", ctl, V_DEF);
    end
    checks++;
    if (hz.WaitCnt !== 32'd0) begin
      errors++;
      $display("FAIL rmw_waitcnt got=%0d exp=0", hz.WaitCnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ctl !== V_DEF) begin
        errors++;
        $display("FAIL rmw_quiet%0d got=%b exp=%b", i, ctl, V_DEF);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    test_reset();
    test_load_use();
    test_branch();
    test_wait3();
    test_timeout();
    test_ready_wins();
    test_deferred_branch();
    test_back_to_back();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
